// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/MEM memory-port arbiter: FSM encodings,
// grant identifiers and helpers that size the latched request bundle.
package mem_port_arbiter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_I_ADDR = 3'd1;
  localparam state_t ST_I_WAIT = 3'd2;
  localparam state_t ST_D_ADDR = 3'd3;
  localparam state_t ST_D_WAIT = 3'd4;
  localparam state_t ST_RESP   = 3'd5;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  // Bundle layout is {wr, wstrb, addr, wdata}.
  function automatic int req_bundle_w(input int aw, input int dw);
    return 1 + dw / 8 + aw + dw;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant selection between the IF and MEM requesters.
// Kept separate so a later cached/uncached port split can reuse it.
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_sel
);

  always_comb begin
    grant_valid = inst_req | data_req;
    grant_sel   = GRANT_DATA;
    if (inst_req && !data_req) begin
      grant_sel = GRANT_INST;
    end else if (inst_req && data_req && RR_EN) begin
      // Contention under round-robin: favour whoever was not served last.
      grant_sel = ~last_grant;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and the MEM stage,
// sequencing address/data handshakes and pulsing data_ok on completion.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_data_ok,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_data_ok,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stallreq_if,
  output logic            stallreq_mem
);

  localparam int SW = strb_w(DW);
  localparam int BW = req_bundle_w(AW, DW);

  state_t          state_reg;
  state_t          state_next;
  logic            last_grant_reg;
  logic [BW-1:0]   bundle_reg;
  logic [BW-1:0]   grant_bundle;
  logic [DW-1:0]   rdata_reg [2];
  logic            grant_valid;
  logic            grant_sel;
  logic            resp;

  arb_pick #(.RR_EN(RR_EN)) u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  // Instruction fetches are always reads, so their write fields are zeroed.
  always_comb begin
    grant_bundle = {1'b0, {SW{1'b0}}, inst_addr, {DW{1'b0}}};
    if (grant_sel == GRANT_DATA) begin
      grant_bundle = {data_wr, data_wstrb, data_addr, data_wdata};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          state_next = (grant_sel == GRANT_DATA) ? ST_D_ADDR : ST_I_ADDR;
        end
      end
      ST_I_ADDR: if (mem_addr_ok) state_next = ST_I_WAIT;
      ST_D_ADDR: if (mem_addr_ok) state_next = ST_D_WAIT;
      ST_I_WAIT, ST_D_WAIT: if (mem_data_ok) state_next = ST_RESP;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= GRANT_INST;
      bundle_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && grant_valid) begin
        last_grant_reg <= grant_sel;
        bundle_reg     <= grant_bundle;
      end
    end
  end

  // Index 0 holds the IF word, index 1 the MEM word; each only updates on its own completion.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rdata
      localparam state_t WAIT_ST = (gi == 0) ? ST_I_WAIT : ST_D_WAIT;
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg[gi] <= '0;
        end else if (state_reg == WAIT_ST && mem_data_ok) begin
          rdata_reg[gi] <= mem_rdata;
        end
      end
    end
  endgenerate

  assign mem_req = (state_reg == ST_I_ADDR) || (state_reg == ST_D_ADDR);
  assign {mem_wr, mem_wstrb, mem_addr, mem_wdata} = bundle_reg;

  assign resp         = (state_reg == ST_RESP);
  assign inst_data_ok = resp && (last_grant_reg == GRANT_INST);
  assign data_data_ok = resp && (last_grant_reg == GRANT_DATA);
  assign inst_rdata   = rdata_reg[0];
  assign data_rdata   = rdata_reg[1];

  assign stallreq_if  = inst_req & ~inst_data_ok;
  assign stallreq_mem = data_req & ~data_data_ok;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory answers the
// port, expected completions are queued per requester when requests are driven.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;

  // Fixed-priority instance shares inputs and the memory handshake.
  logic [31:0] fp_inst_rdata;
  logic        fp_inst_data_ok;
  logic [31:0] fp_data_rdata;
  logic        fp_data_data_ok;
  logic        fp_mem_req;
  logic        fp_mem_wr;
  logic [3:0]  fp_mem_wstrb;
  logic [31:0] fp_mem_addr;
  logic [31:0] fp_mem_wdata;
  logic        fp_stallreq_if;
  logic        fp_stallreq_mem;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(fp_inst_rdata), .inst_data_ok(fp_inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(fp_data_rdata), .data_data_ok(fp_data_data_ok),
    .mem_req(fp_mem_req), .mem_wr(fp_mem_wr), .mem_wstrb(fp_mem_wstrb), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .stallreq_if(fp_stallreq_if), .stallreq_mem(fp_stallreq_mem)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t inst_q[$];
  txn_t data_q[$];
  logic grant_log[$];   // 1 = data granted, 0 = inst granted

  int checks = 0;
  int errors = 0;
  bit mem_en = 1'b0;
  bit sb_on  = 1'b1;
  int addr_delay = 0;
  int data_delay = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_BFAF;
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Behavioural memory: accepts an address after addr_delay cycles of mem_req,
  // then returns data after data_delay further cycles.
  initial begin : mem_model
    int   acnt;
    int   dcnt;
    bit   phase;
    logic [31:0] resp_word;
    logic is_inst;
    acnt = 0; dcnt = 0; phase = 1'b0; resp_word = '0;
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        phase = 1'b0; acnt = 0; dcnt = 0;
      end else begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (phase) begin
          if (dcnt == data_delay) begin
            mem_data_ok = 1'b1;
            mem_rdata   = resp_word;
            phase       = 1'b0;
          end else dcnt++;
        end else if (mem_req) begin
          if (acnt == addr_delay) begin
            mem_addr_ok = 1'b1;
            resp_word   = mem_fn(mem_addr);
            phase = 1'b1; dcnt = 0; acnt = 0;
            if (sb_on) begin
              is_inst = (mem_addr[31:28] == 4'hB);
              grant_log.push_back(!is_inst);
              checks++;
              if (is_inst) begin
                if (inst_q.size() == 0 || mem_addr !== inst_q[0].addr || mem_wr !== 1'b0 || mem_wstrb !== 4'h0) begin
                  errors++;
                  $display("FAIL inst_addr_phase: got addr=%h wr=%b wstrb=%h, expected addr=%h wr=0 wstrb=0 (queued=%0d)",
                           mem_addr, mem_wr, mem_wstrb, (inst_q.size() != 0) ? inst_q[0].addr : 32'h0, inst_q.size());
                end
              end else begin
                if (data_q.size() == 0 || mem_addr !== data_q[0].addr || mem_wr !== data_q[0].wr ||
                    mem_wstrb !== data_q[0].wstrb || (data_q[0].wr && mem_wdata !== data_q[0].wdata)) begin
                  errors++;
                  $display("FAIL data_addr_phase: got addr=%h wr=%b wstrb=%h wdata=%h (queued=%0d)",
                           mem_addr, mem_wr, mem_wstrb, mem_wdata, data_q.size());
                end
              end
            end
          end else acnt++;
        end
      end
    end
  end

  // Completion scoreboard: pops the oldest expected word on each data_ok pulse.
  initial begin : monitor
    txn_t e;
    forever begin
      @(negedge clk);
      if (sb_on && inst_data_ok) begin
        checks++;
        if (inst_q.size() == 0) begin
          errors++;
          $display("FAIL inst_unexpected_ok: got inst_data_ok=1, expected no completion");
        end else begin
          e = inst_q.pop_front();
          if (inst_rdata !== e.rdata) begin
            errors++;
            $display("FAIL inst_rdata: got %h, expected %h (addr %h)", inst_rdata, e.rdata, e.addr);
          end
        end
      end
      if (sb_on && data_data_ok) begin
        checks++;
        if (data_q.size() == 0) begin
          errors++;
          $display("FAIL data_unexpected_ok: got data_data_ok=1, expected no completion");
        end else begin
          e = data_q.pop_front();
          if (data_rdata !== e.rdata) begin
            errors++;
            $display("FAIL data_rdata: got %h, expected %h (addr %h)", data_rdata, e.rdata, e.addr);
          end
        end
      end
      if (inst_data_ok && data_data_ok) begin
        checks++;
        errors++;
        $display("FAIL both_ok: got inst_data_ok=1 data_data_ok=1, expected at most one");
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    inst_q.delete();
    data_q.delete();
    grant_log.delete();
  endtask

  task automatic test_reset();
    inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem_port: got req=%b wr=%b wstrb=%h addr=%h wdata=%h, expected all 0",
               mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata);
    end
    checks++;
    if ({inst_data_ok, data_data_ok, stallreq_if, stallreq_mem} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 0000", {inst_data_ok, data_data_ok, stallreq_if, stallreq_mem});
    end
    checks++;
    if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got inst=%h data=%h, expected 0/0", inst_rdata, data_rdata);
    end
  endtask

  task automatic test_fixed_priority();
    int n_i;
    int n_d;
    int t;
    sb_on = 1'b0; mem_en = 1'b1; addr_delay = 0; data_delay = 0;
    n_i = 0; n_d = 0;
    @(negedge clk);
    inst_addr = 32'hBFC0_0010; inst_req = 1'b1;
    data_addr = 32'h8000_0010; data_wr = 1'b0; data_wstrb = 4'hF; data_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_i += int'(fp_inst_data_ok);
      n_d += int'(fp_data_data_ok);
    end
    data_req = 1'b0;
    checks++;
    if (n_d != 4 || n_i != 0) begin
      errors++;
      $display("FAIL fp_contention: got data=%0d inst=%0d completions in 16 cycles, expected 4/0", n_d, n_i);
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(fp_inst_data_ok || fp_data_data_ok) && t < 10);
    checks++;
    if (!(fp_inst_data_ok === 1'b1 && fp_data_data_ok === 1'b0)) begin
      errors++;
      $display("FAIL fp_inst_after_drop: got inst_ok=%b data_ok=%b after %0d cycles, expected inst_ok=1 data_ok=0",
               fp_inst_data_ok, fp_data_data_ok, t);
    end
    inst_req = 1'b0;
    repeat (6) @(negedge clk);
    sb_on = 1'b1;
    do_reset();
  endtask

  task automatic test_single_if();
    txn_t e;
    int   cyc;
    bit   got;
    addr_delay = 0; data_delay = 0; mem_en = 1'b1;
    e = '{addr: 32'hBFC0_0000, wr: 1'b0, wstrb: 4'h0, wdata: 32'h0, rdata: 32'h3C08_BFAF};
    inst_q.push_back(e);
    @(negedge clk);
    inst_addr = 32'hBFC0_0000;
    inst_req  = 1'b1;
    #1;
    checks++;
    if (stallreq_if !== 1'b1) begin
      errors++;
      $display("FAIL if_stall_c0: got %b, expected 1", stallreq_if);
    end
    cyc = 0; got = 1'b0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (inst_data_ok) got = 1'b1;
      else begin
        checks++;
        if (stallreq_if !== 1'b1) begin
          errors++;
          $display("FAIL if_stall_c%0d: got %b, expected 1", cyc, stallreq_if);
        end
        if (cyc == 1) begin
          checks++;
          if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0000 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL if_addr_c1: got req=%b addr=%h wr=%b, expected 1/bfc00000/0", mem_req, mem_addr, mem_wr);
          end
        end
      end
    end
    checks++;
    if (!got || cyc != 3) begin
      errors++;
      $display("FAIL if_latency: got data_ok at cycle %0d (seen=%b), expected cycle 3", cyc, got);
    end
    checks++;
    if (stallreq_if !== 1'b0) begin
      errors++;
      $display("FAIL if_stall_ok: got %b during data_ok, expected 0", stallreq_if);
    end
    inst_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (inst_rdata !== 32'h3C08_BFAF) begin
      errors++;
      $display("FAIL if_rdata_hold: got %h, expected 3c08bfaf", inst_rdata);
    end
  endtask

  task automatic test_store_wait();
    txn_t e;
    int   req_cycles;
    int   t;
    addr_delay = 3; data_delay = 0; mem_en = 1'b1;
    e = '{addr: 32'h8000_1002, wr: 1'b1, wstrb: 4'b0100, wdata: 32'h00AB_0000, rdata: mem_fn(32'h8000_1002)};
    data_q.push_back(e);
    @(negedge clk);
    data_addr = e.addr; data_wr = 1'b1; data_wstrb = e.wstrb; data_wdata = e.wdata; data_req = 1'b1;
    req_cycles = 0; t = 0;
    do begin
      @(negedge clk);
      t++;
      if (mem_req) begin
        req_cycles++;
        checks++;
        if (mem_addr !== e.addr || mem_wr !== 1'b1 || mem_wstrb !== e.wstrb || mem_wdata !== e.wdata) begin
          errors++;
          $display("FAIL store_fields: got addr=%h wr=%b wstrb=%b wdata=%h, expected %h/1/%b/%h",
                   mem_addr, mem_wr, mem_wstrb, mem_wdata, e.addr, e.wstrb, e.wdata);
        end
      end
    end while (!data_data_ok && t < 20);
    data_req = 1'b0; data_wr = 1'b0;
    checks++;
    if (!data_data_ok || req_cycles != 4) begin
      errors++;
      $display("FAIL store_req_hold: got mem_req high %0d cycles (done=%b), expected 4", req_cycles, data_data_ok);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
        errors++;
        $display("FAIL store_extra_pulse: got data_ok=%b inst_ok=%b, expected 0/0", data_data_ok, inst_data_ok);
      end
    end
    addr_delay = 0;
  endtask

  task automatic run_inst(input int n);
    txn_t e;
    int   t;
    for (int k = 0; k < n; k++) begin
      e = '{addr: 32'hBFC0_0100 + 32'(k * 4), wr: 1'b0, wstrb: 4'h0, wdata: 32'h0, rdata: 32'h0};
      e.rdata = mem_fn(e.addr);
      inst_q.push_back(e);
      inst_addr = e.addr;
      inst_req  = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!inst_data_ok && t < 40);
      checks++;
      if (!inst_data_ok || t < 3) begin
        errors++;
        $display("FAIL rr_inst_%0d: got data_ok=%b after %0d cycles, expected pulse after >=3", k, inst_data_ok, t);
      end
    end
    inst_req = 1'b0;
  endtask

  task automatic run_data(input int n);
    txn_t e;
    int   t;
    for (int k = 0; k < n; k++) begin
      e = '{addr: 32'h8000_0200 + 32'(k * 4), wr: k[0], wstrb: 4'hF,
            wdata: 32'h1111_1111 * 32'(k + 1), rdata: 32'h0};
      e.rdata = mem_fn(e.addr);
      data_q.push_back(e);
      data_addr = e.addr; data_wr = e.wr; data_wstrb = e.wstrb; data_wdata = e.wdata;
      data_req  = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!data_data_ok && t < 40);
      checks++;
      if (!data_data_ok || t < 3) begin
        errors++;
        $display("FAIL rr_data_%0d: got data_ok=%b after %0d cycles, expected pulse after >=3", k, data_data_ok, t);
      end
    end
    data_req = 1'b0; data_wr = 1'b0;
  endtask

  task automatic test_round_robin();
    addr_delay = 0; data_delay = 0; mem_en = 1'b1;
    do_reset();
    fork
      run_inst(4);
      run_data(4);
    join
    repeat (2) @(negedge clk);
    checks++;
    if (grant_log.size() != 8) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d grants, expected 8", grant_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (grant_log[k] !== (k % 2 == 0)) begin
          errors++;
          $display("FAIL rr_order_%0d: got %s, expected %s", k, grant_log[k] ? "data" : "inst",
                   (k % 2 == 0) ? "data" : "inst");
        end
      end
    end
  endtask

  task automatic test_spurious();
    txn_t e;
    mem_en = 1'b0;
    @(negedge clk);
    mem_addr_ok = 1'b0; mem_rdata = 32'hDEAD_BEEF; mem_data_ok = 1'b1;
    @(negedge clk);
    mem_data_ok = 1'b0;
    checks++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL spur_idle: got inst_ok=%b data_ok=%b req=%b, expected 0/0/0", inst_data_ok, data_data_ok, mem_req);
    end
    e = '{addr: 32'hBFC0_0040, wr: 1'b0, wstrb: 4'h0, wdata: 32'h0, rdata: 32'h1234_5678};
    inst_q.push_back(e);
    inst_addr = e.addr; inst_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || inst_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL spur_grant: got req=%b inst_ok=%b, expected 1/0", mem_req, inst_data_ok);
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    inst_req = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL spur_wait_entry: got req=%b, expected 0", mem_req);
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || inst_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL spur_wait_addr_ok: got req=%b inst_ok=%b, expected 0/0", mem_req, inst_data_ok);
    end
    mem_rdata = 32'h1234_5678; mem_data_ok = 1'b1;
    @(negedge clk);
    mem_data_ok = 1'b0;
    checks++;
    if (inst_data_ok !== 1'b1) begin
      errors++;
      $display("FAIL spur_dropped_req_ok: got inst_ok=%b, expected 1", inst_data_ok);
    end
    @(negedge clk);
    checks++;
    if (inst_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL spur_single_pulse: got inst_ok=%b, expected 0", inst_data_ok);
    end
  endtask

  task automatic test_reset_mid();
    mem_en = 1'b0;
    @(negedge clk);
    data_addr = 32'h8000_0300; data_wr = 1'b0; data_wstrb = 4'hF; data_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_grant: got req=%b, expected 1", mem_req);
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    rst = 1'b1;
    data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || data_data_ok !== 1'b0 || inst_data_ok !== 1'b0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_state: got req=%b data_ok=%b inst_ok=%b data_rdata=%h, expected 0/0/0/0",
               mem_req, data_data_ok, inst_data_ok, data_rdata);
    end
    mem_rdata = 32'hCAFE_F00D; mem_data_ok = 1'b1;
    @(negedge clk);
    mem_data_ok = 1'b0;
    checks++;
    if (data_data_ok !== 1'b0 || data_rdata !== 32'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_late_ok: got data_ok=%b data_rdata=%h req=%b, expected 0/0/0",
               data_data_ok, data_rdata, mem_req);
    end
    @(negedge clk);
    checks++;
    if (data_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_pulse: got data_ok=%b, expected 0", data_data_ok);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_single_if();
    test_store_wait();
    test_round_robin();
    test_spurious();
    test_reset_mid();
    checks++;
    if (inst_q.size() != 0 || data_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d inst / %0d data pending, expected 0/0", inst_q.size(), data_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
